// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one async FIFO write port among num_req
// requesters, granting each owner a bounded burst and never writing into a full FIFO.
module fifo_wr_arbiter #(
   parameter int unsigned data_width = 8,
   parameter int unsigned num_req    = 4,
   parameter int unsigned max_burst  = 4
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic [num_req-1:0]            req,
   input  logic [num_req*data_width-1:0] req_data,
   output logic [num_req-1:0]            ack,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [data_width-1:0]         fifo_wdata,
   output logic                          grant_valid,
   output logic [$clog2(num_req)-1:0]    grant_id,
   output logic [15:0]                   stall_cnt
);

   localparam int unsigned     ID_W      = $clog2(num_req);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(num_req - 1);
   localparam logic [3:0]      LAST_BEAT = 4'(max_burst - 1);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       owner_q, owner_d;
   logic [3:0]            beat_q, beat_d;
   logic [15:0]           stall_q, stall_d;

   logic [data_width-1:0] words [num_req];
   logic [ID_W-1:0]       pick_id;
   logic                  pick_found;
   logic [ID_W-1:0]       next_ptr;
   logic                  accept;
   int unsigned           cand_idx;
   logic [ID_W-1:0]       cand;

   for (genvar gi = 0; gi < num_req; gi++) begin : g_unpack
      assign words[gi] = req_data[gi*data_width +: data_width];
   end

   // First requester at or after rr_ptr, wrapping modulo num_req.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand_idx   = 0;
      cand       = '0;
      for (int unsigned k = 0; k < num_req; k++) begin
         cand_idx = 32'(rr_ptr_q) + k;
         if (cand_idx >= num_req) begin
            cand_idx = cand_idx - num_req;
         end
         cand = ID_W'(cand_idx);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign accept   = (state_q == BURST) && req[owner_q] && !fifo_full;
   assign next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

   always_comb begin
      ack        = '0;
      fifo_wdata = '0;
      if (accept) begin
         ack[owner_q] = 1'b1;
         fifo_wdata   = words[owner_q];
      end
   end

   assign fifo_wr_en  = accept;
   assign grant_valid = (state_q == BURST);
   assign grant_id    = owner_q;
   assign stall_cnt   = stall_q;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      beat_d   = beat_q;
      stall_d  = stall_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BURST;
               owner_d = pick_id;
               beat_d  = '0;
            end
         end
         BURST: begin
            // Release on the last beat or when the owner withdraws; a full
            // FIFO only holds the grant and counts the stall.
            if (accept) begin
               if (beat_q == LAST_BEAT) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
                  beat_d   = '0;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end else if (!req[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
               beat_d   = '0;
            end else if (stall_q != '1) begin
               stall_d = stall_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         beat_q   <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         beat_q   <= beat_d;
         stall_q  <= stall_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus a
// looped round-robin sequence with hand-derived expectations.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wdata;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic [15:0] stall_cnt;

   int n_vec = 0;
   int n_bad = 0;

   fifo_wr_arbiter #(
      .data_width(8),
      .num_req   (4),
      .max_burst (4)
   ) dut (
      .wr_clk     (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_wdata (fifo_wdata),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] data;
      logic        full;
      logic        chk;
      logic [3:0]  ack;
      logic        wr;
      logic [7:0]  wdata;
      logic        gv;
      logic [1:0]  gid;
      logic [15:0] stall;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [3:0] q, input logic [31:0] d,
                               input logic f, input logic c, input logic [3:0] a,
                               input logic w, input logic [7:0] wd, input logic g,
                               input logic [1:0] id, input logic [15:0] s);
      vec_t v;
      v.rst = r; v.req = q; v.data = d; v.full = f; v.chk = c;
      v.ack = a; v.wr = w; v.wdata = wd; v.gv = g; v.gid = id; v.stall = s;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
      end
   endtask

   // Writing into a full FIFO is never allowed, whatever the test.
   always @(negedge clk) begin
      if (fifo_full === 1'b1) begin
         n_vec++;
         if (fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_en_while_full: got %b want 0", fifo_wr_en);
         end
      end
   end

   task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] d,
                        input logic f);
      @(posedge clk);
      #1;
      rst = r; req = q; req_data = d; fifo_full = f;
      @(negedge clk);
   endtask

   initial begin
      int writes;
      int ph;
      int g;
      int gprev;

      rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;

      // Basic burst of two words from requester 0, then rr_ptr=1 pick
      add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0001, 32'h000000A5, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0001, 32'h000000A5, 0, 1, 4'b0001, 1, 8'hA5, 1, 2'd0, 16'd0);
      add(0, 4'b0001, 32'h0000003C, 0, 1, 4'b0001, 1, 8'h3C, 1, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0011, 32'h00002211, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0011, 32'h00002211, 0, 1, 4'b0010, 1, 8'h22, 1, 2'd1, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd1, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd1, 16'd0);

      // rr_ptr=3 wrap: requester 3 before 0
      add(0, 4'b0100, 32'h00770000, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd1, 16'd0);
      add(0, 4'b0100, 32'h00770000, 0, 1, 4'b0100, 1, 8'h77, 1, 2'd2, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd2, 16'd0);
      add(0, 4'b1001, 32'hD30000A0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd2, 16'd0);
      add(0, 4'b1001, 32'hD30000A0, 0, 1, 4'b1000, 1, 8'hD3, 1, 2'd3, 16'd0);
      add(0, 4'b0001, 32'hD30000A0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd3, 16'd0);
      add(0, 4'b0001, 32'hD30000A0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd3, 16'd0);
      add(0, 4'b0001, 32'hD30000A0, 0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd0, 16'd0);

      // Owner 2 stalled by full for 5 cycles mid-burst
      add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0100, 32'h00200000, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0100, 32'h00200000, 0, 1, 4'b0100, 1, 8'h20, 1, 2'd2, 16'd0);
      add(0, 4'b0100, 32'h00210000, 0, 1, 4'b0100, 1, 8'h21, 1, 2'd2, 16'd0);
      for (int k = 0; k < 5; k++)
         add(0, 4'b0100, 32'h00220000, 1, 1, 4'b0000, 0, 8'h00, 1, 2'd2, 16'(k));
      add(0, 4'b0100, 32'h00220000, 0, 1, 4'b0100, 1, 8'h22, 1, 2'd2, 16'd5);
      add(0, 4'b0100, 32'h00230000, 0, 1, 4'b0100, 1, 8'h23, 1, 2'd2, 16'd5);
      add(0, 4'b0100, 32'h00240000, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd2, 16'd5);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 1, 2'd2, 16'd5);

      // Full from grant start: arbitration cycle not counted as a stall
      add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0010, 32'h00009900, 1, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      for (int k = 0; k < 9; k++)
         add(0, 4'b0010, 32'h00009900, 1, 1, 4'b0000, 0, 8'h00, 1, 2'd1, 16'(k));
      add(0, 4'b0000, 32'h0, 1, 1, 4'b0000, 0, 8'h00, 1, 2'd1, 16'd9);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd1, 16'd9);

      // Reset pulse during beat 2 of requester 1's burst
      add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0010, 32'h00005A00, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0010, 32'h00005A00, 0, 1, 4'b0010, 1, 8'h5A, 1, 2'd1, 16'd0);
      add(0, 4'b0010, 32'h00005B00, 1, 1, 4'b0000, 0, 8'h00, 1, 2'd1, 16'd0);
      add(0, 4'b0010, 32'h00005B00, 0, 1, 4'b0010, 1, 8'h5B, 1, 2'd1, 16'd1);
      add(1, 4'b0011, 32'h00005C11, 0, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0011, 32'h00005C11, 0, 1, 4'b0000, 0, 8'h00, 0, 2'd0, 16'd0);
      add(0, 4'b0011, 32'h00005C11, 0, 1, 4'b0001, 1, 8'h11, 1, 2'd0, 16'd0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].full);
         if (tbl[i].chk) begin
            chk("ack",         i, 32'(ack),         32'(tbl[i].ack));
            chk("fifo_wr_en",  i, 32'(fifo_wr_en),  32'(tbl[i].wr));
            chk("fifo_wdata",  i, 32'(fifo_wdata),  32'(tbl[i].wdata));
            chk("grant_valid", i, 32'(grant_valid), 32'(tbl[i].gv));
            chk("grant_id",    i, 32'(grant_id),    32'(tbl[i].gid));
            chk("stall_cnt",   i, 32'(stall_cnt),   32'(tbl[i].stall));
         end
      end

      // All four requesting: 0,1,2,3,0 with four beats and one idle cycle each
      drive(1'b1, 4'b0000, 32'h0, 1'b0);
      drive(1'b1, 4'b0000, 32'h0, 1'b0);
      writes = 0;
      for (int c = 0; c < 22; c++) begin
         drive(1'b0, 4'b1111, 32'h35251505, 1'b0);
         ph = c % 5;
         g  = (c / 5) % 4;
         gprev = (c < 5) ? 0 : ((c / 5) - 1) % 4;
         if (c < 20 && fifo_wr_en === 1'b1) writes++;
         if (ph == 0) begin
            chk("rr.ack",      c, 32'(ack),         32'h0);
            chk("rr.wr_en",    c, 32'(fifo_wr_en),  32'h0);
            chk("rr.gvalid",   c, 32'(grant_valid), 32'h0);
            chk("rr.grant_id", c, 32'(grant_id),    32'(gprev));
         end else begin
            chk("rr.ack",      c, 32'(ack),         32'h1 << g);
            chk("rr.wr_en",    c, 32'(fifo_wr_en),  32'h1);
            chk("rr.wdata",    c, 32'(fifo_wdata),  32'((g << 4) | 5));
            chk("rr.gvalid",   c, 32'(grant_valid), 32'h1);
            chk("rr.grant_id", c, 32'(grant_id),    32'(g));
         end
      end
      chk("rr.writes_in_20", 0, 32'(writes), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of async_fifo among num_req requesters in the write-clock domain.
- Grants one requester at a time for a bounded burst and drives the FIFO wr_en/wdata directly.
- Never issues a write while the FIFO reports full, so FIFO overflow cannot originate from this block.
- Sits between producer blocks and the FIFO write side.

Parameters:
- data_width, 8, width of each requester's data word and of fifo_wdata
- num_req, 4, number of requesters (2..8)
- max_burst, 4, maximum words accepted from one owner per grant (1..15)

Ports:
- wr_clk  input  1  write-domain clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  num_req  per-requester "word available" flag; bit i paired with word i of req_data
- req_data  input  num_req*data_width  packed data; requester i occupies bits [i*data_width +: data_width]
- ack  output  num_req  one-hot or zero; ack[i]=1 means req_data word i is written this cycle
- fifo_full  input  1  full flag from the FIFO write side
- fifo_wr_en  output  1  FIFO write enable
- fifo_wdata  output  data_width  FIFO write data
- grant_valid  output  1  an owner currently holds the port (state BURST)
- grant_id  output  $clog2(num_req)  current owner index; holds last owner when idle
- stall_cnt  output  16  cycles spent in BURST with req[owner]=1 and fifo_full=1; saturates at 16'hFFFF

Behaviour:
- Reset (rst=1 at a wr_clk edge), applied regardless of state:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, stall_cnt=0.
  - ack=0, fifo_wr_en=0, grant_valid=0, fifo_wdata=0.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod num_req.
  - Register owner=i, beat_cnt=0, state=BURST.
  - IDLE never writes; this costs exactly one arbitration cycle per grant.
- State BURST, combinational outputs:
  - accept = req[owner] & ~fifo_full.
  - ack[owner] = accept, all other ack bits = 0.
  - fifo_wr_en = accept.
  - fifo_wdata = req_data word of owner when accept, else 0.
  - Zero-cycle latency from req to write.
- State BURST, on each edge:
  - If accept, beat_cnt++.
  - If accept and beat_cnt+1==max_burst: release.
  - Else if req[owner]==0: release, no write that cycle.
  - Else if fifo_full: stay (stall), stall_cnt++ saturating, keep beat_cnt.
  - Release: state=IDLE, rr_ptr=(owner+1) mod num_req, beat_cnt=0.
- fifo_full=1 takes priority:
  - Never assert fifo_wr_en while fifo_full=1, in any state.
  - The owner keeps its grant through a stall; no preemption on full.
- Simultaneous requests:
  - Only the owner is acked.
  - Other requesters must hold req and data stable until their ack.
- Requester side: a word is consumed only in a cycle with ack[i]=1; req may drop at any time with no word lost.
- Fairness: after a release the next search starts at owner+1, so each active requester is granted within num_req grants.
- Reset mid-burst: takes effect at the next edge; outputs go to reset values in the following cycle; no partial word is written after the reset edge.
- Status outputs:
  - grant_valid = (state==BURST).
  - grant_id is registered.
  - stall_cnt clears only on reset.

Test Plan:
- Reset then req=4'b0001 with data 8'hA5, 8'h3C, then req drops -> IDLE one cycle, then BURST; fifo_wr_en high 2 cycles writing A5, 3C; ack[0] on both; then back to IDLE with rr_ptr=1.
- req=4'b1111 held, each requester sending its index in the high nibble, max_burst=4, FIFO never full -> grant order 0,1,2,3,0; exactly 4 writes per grant; one idle cycle between bursts; 16 writes in 20 cycles.
- Owner 2 in BURST, fifo_full forced high for 5 cycles mid-burst -> fifo_wr_en=0 and ack=0 for those 5 cycles; grant_id stays 2; stall_cnt=5; burst resumes with the remaining beats and no duplicated or lost data.
- fifo_full=1 at grant start with req=4'b0010 held for 10 cycles -> zero writes; stall_cnt=9 (arbitration cycle excluded); FIFO overflow flag never asserts.
- req=4'b1001 with rr_ptr=3 -> requester 3 granted first, then 0; rr_ptr wraps correctly.
- rst pulsed for one cycle during beat 2 of a burst -> next cycle fifo_wr_en=0, grant_valid=0, stall_cnt=0; with req still high, arbitration restarts from requester 0.
